fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Multicycle front end that sits directly upstream of control_unit.
- Owns the PC, issues instruction-memory reads, and latches the fetched word that drives control_unit's inst.
- Sequences the data-memory phase from control_unit's dREN/dWEN, and drops every memory request once its hit returns.
- Stops the machine permanently on halt.

Parameters:
- PC_INIT, 32'h0000_0000, PC value loaded on reset.
- WORD_W, 32, instruction and address width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- ihit  in  1  instruction memory read complete.
- iload  in  WORD_W  instruction data; valid only while ihit=1.
- dhit  in  1  data memory access complete.
- cu_dREN  in  1  control_unit dREN for the latched instruction.
- cu_dWEN  in  1  control_unit dWEN for the latched instruction.
- cu_halt  in  1  control_unit halt for the latched instruction.
- redirect  in  1  datapath requests a non-sequential next PC (branch taken, jump, jr).
- redirect_pc  in  WORD_W  target PC; used when redirect=1.
- imemREN  out  1  instruction read request.
- imemaddr  out  WORD_W  instruction address (current PC).
- dmemREN  out  1  data read request.
- dmemWEN  out  1  data write request.
- inst  out  WORD_W  latched instruction, feeds control_unit inst.
- pc  out  WORD_W  current PC.
- pc_plus4  out  WORD_W  pc + 4, used by the JAL link value.
- commit  out  1  one-cycle pulse when an instruction retires (PC advances).
- halted  out  1  sticky halt flag.

Behaviour:
- State machine: FETCH, EXEC, MEM, HALT. It is encoded as fsm_state_t.
- Reset values (also the result of RST asserted in any state, mid-access included):
  - State is FETCH and pc = PC_INIT.
  - inst = 32'h0 (decodes as sll $0, a nop).
  - halted = 0 and commit = 0.
  - All requests go low in the reset cycle. A hit that arrives in the same cycle as RST is ignored.
- Outputs that are pure functions of state and pc:
  - imemaddr = pc, in every state.
  - pc_plus4 = pc + 4, modulo 2^32 (0xFFFF_FFFC + 4 = 0).
- FETCH:
  - imemREN = 1; dmemREN = dmemWEN = 0.
  - On ihit: inst <= iload, then go to EXEC.
  - Without ihit: stay in FETCH and keep the request asserted (no request timeout).
  - dhit is ignored in FETCH.
- EXEC, exactly one cycle, with the control_unit decode of inst valid. Checked in this priority order:
  - cu_halt=1: go to HALT and set halted <= 1. No commit. pc is unchanged and keeps pointing at the halt instruction.
  - Else cu_dREN or cu_dWEN: go to MEM. pc is unchanged.
  - Else: pc <= redirect ? redirect_pc : pc + 4, commit = 1, go to FETCH.
  - All requests are low in EXEC.
- MEM:
  - dmemREN = cu_dREN and dmemWEN = cu_dWEN, both combinational from the latched inst. imemREN = 0.
  - If cu_dREN and cu_dWEN are both 1 (illegal decode), only dmemWEN is asserted.
  - On dhit: pc <= redirect ? redirect_pc : pc + 4, commit = 1, go to FETCH.
  - Requests drop in the cycle after dhit, because the state is then FETCH.
  - ihit is ignored in MEM.
- HALT: absorbing state. All requests are 0 and halted = 1. Only RST leaves HALT.
- Redirect is sampled only in the cycle that commits; it is ignored elsewhere. redirect_pc[1:0] is passed through unmodified.
- Latency:
  - Non-memory instruction with a same-cycle ihit: 2 cycles (FETCH, EXEC).
  - Load/store with same-cycle hits: 3 cycles.
  - Each wait cycle on ihit or dhit adds 1.
- inst changes only on the FETCH-state ihit edge, so control_unit outputs stay stable through EXEC and MEM.

Decomposition:
- cpu_types_pkg gains fsm_state_t (FETCH, EXEC, MEM, HALT) and the constant PC_STEP = 4.
- The existing word_t is reused for inst, pc and the targets.
- One natural sub-module: pc_reg, which holds the PC register, the +4 adder and the redirect mux, enabled by commit.
- The FSM and the instruction latch stay in fetch_sequencer.

Test Plan:
- Reset then ihit=1 with iload=0x2008_0005 (addi): inst=0x2008_0005 in cycle 2, commit in cycle 2, pc=0x4 in cycle 3, imemREN=1 again in cycle 3.
- Load with dhit delayed 3 cycles: dmemREN=1 for exactly 4 cycles, imemREN=0 throughout, then pc advances by 4 and dmemREN drops the next cycle.
- Store with redirect=1 and redirect_pc=0x40 at the dhit cycle: dmemWEN pulse ends, pc=0x40, and exactly one commit.
- Branch: non-memory inst with redirect=1 and redirect_pc=0x100 in EXEC gives pc=0x100; redirect=1 during FETCH has no effect.
- Halt inst (0xFFFF_FFFF) with cu_halt=1: halted=1, pc frozen, all requests 0 for 20 cycles despite ihit/dhit toggling.
- RST asserted while in MEM with dhit high in the same cycle: next state is FETCH, pc=PC_INIT, no commit, dmemREN=0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, front-end sequencer states and PC step.
package cpu_types_pkg;

    localparam int WORD_BITS = 32;

    typedef logic [WORD_BITS-1:0] word_t;

    // Front-end sequencing phases of the multicycle machine.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        MEM   = 2'd2,
        HALT  = 2'd3
    } fsm_state_t;

    // Sequential instruction stride in bytes.
    localparam word_t PC_STEP = 32'd4;

    // True when the decoded instruction needs a data-memory phase.
    function automatic logic needs_mem(input logic ren, input logic wen);
        return ren | wen;
    endfunction

endpackage

// File: rtl/fetch_sequencer_pc_reg.sv
// Program counter with sequential increment and redirect mux.
// The PC only moves when an instruction retires (en high).
module pc_reg
    import cpu_types_pkg::*;
#(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter int          WORD_W  = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              en,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    output logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] pc_plus4
);

    logic [WORD_W-1:0] pc_q;
    logic [WORD_W-1:0] pc_next;

    // Sequential successor wraps modulo 2^WORD_W; the link value reuses it.
    assign pc_plus4 = pc_q + WORD_W'(PC_STEP);

    // Target selection: redirect target is taken verbatim, low bits included.
    always_comb begin
        pc_next = pc_plus4;
        if (redirect) begin
            pc_next = redirect_pc;
        end
    end

    // PC register, loaded with the reset vector and advanced on retire.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q <= WORD_W'(PC_INIT);
        end else if (en) begin
            pc_q <= pc_next;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Multicycle front end: owns the PC, fetches and latches instructions for
// control_unit, sequences the data-memory phase and stops for good on halt.
module fetch_sequencer
    import cpu_types_pkg::*;
#(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter int          WORD_W  = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ihit,
    input  logic [WORD_W-1:0] iload,
    input  logic              dhit,
    input  logic              cu_dREN,
    input  logic              cu_dWEN,
    input  logic              cu_halt,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    output logic              imemREN,
    output logic [WORD_W-1:0] imemaddr,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] inst,
    output logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] pc_plus4,
    output logic              commit,
    output logic              halted
);

    fsm_state_t        state;
    logic [WORD_W-1:0] inst_q;
    logic              halted_q;
    logic              exec_retire;
    logic              mem_retire;

    // A non-memory, non-halt instruction retires straight out of EXEC;
    // a load/store retires when its data hit returns.
    assign exec_retire = (state == EXEC) && !cu_halt && !needs_mem(cu_dREN, cu_dWEN);
    assign mem_retire  = (state == MEM) && dhit;

    // Memory requests and retire pulse, all forced low while reset is held
    // so that a hit coinciding with reset has no effect.
    always_comb begin
        imemREN = 1'b0;
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
        commit  = 1'b0;
        if (!RST) begin
            case (state)
                FETCH: imemREN = 1'b1;
                MEM: begin
                    // An illegal read+write decode is treated as a write only.
                    dmemWEN = cu_dWEN;
                    dmemREN = cu_dREN & ~cu_dWEN;
                end
                default: begin
                    imemREN = 1'b0;
                end
            endcase
            commit = exec_retire | mem_retire;
        end
    end

    // Sequencer FSM plus instruction latch and sticky halt flag.
    // inst only moves on the fetch hit, keeping the decode stable in EXEC/MEM.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= FETCH;
            inst_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (ihit) begin
                        inst_q <= iload;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    if (cu_halt) begin
                        state    <= HALT;
                        halted_q <= 1'b1;
                    end else if (needs_mem(cu_dREN, cu_dWEN)) begin
                        state <= MEM;
                    end else begin
                        state <= FETCH;
                    end
                end
                MEM: begin
                    if (dhit) begin
                        state <= FETCH;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

    pc_reg #(
        .PC_INIT (PC_INIT),
        .WORD_W  (WORD_W)
    ) u_pc_reg (
        .CLK         (CLK),
        .RST         (RST),
        .en          (commit),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pc          (pc),
        .pc_plus4    (pc_plus4)
    );

    assign imemaddr = pc;
    assign inst     = inst_q;
    assign halted   = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a transaction-level model is checked
// against the DUT on every falling edge, plus hand-computed spot checks.
module tb_fetch_sequencer;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ihit = 1'b0;
    logic [31:0] iload = 32'h0;
    logic        dhit = 1'b0;
    logic        cu_dREN = 1'b0;
    logic        cu_dWEN = 1'b0;
    logic        cu_halt = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        commit;
    logic        halted;

    int total = 0;
    int bad   = 0;
    int ncommit = 0;

    fetch_sequencer #(
        .PC_INIT (32'h0000_0000),
        .WORD_W  (32)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .ihit        (ihit),
        .iload       (iload),
        .dhit        (dhit),
        .cu_dREN     (cu_dREN),
        .cu_dWEN     (cu_dWEN),
        .cu_halt     (cu_halt),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imemREN     (imemREN),
        .imemaddr    (imemaddr),
        .dmemREN     (dmemREN),
        .dmemWEN     (dmemWEN),
        .inst        (inst),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .commit      (commit),
        .halted      (halted)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The machine is described by what it is waiting for: an instruction
    // word, a one-cycle decode, or a data hit; or it is stopped.
    logic        m_live = 1'b0;
    logic        m_want_inst, m_decoding, m_want_data, m_stopped;
    logic [31:0] m_pc, m_inst;

    always @(negedge CLK) begin
        logic retire;
        logic is_mem;
        is_mem = cu_dREN | cu_dWEN;
        retire = !RST && ((m_decoding && !cu_halt && !is_mem) || (m_want_data && dhit));
        if (m_live) begin
            check("m_imemREN", {31'b0, imemREN}, {31'b0, !RST && m_want_inst});
            check("m_dmemREN", {31'b0, dmemREN}, {31'b0, !RST && m_want_data && cu_dREN && !cu_dWEN});
            check("m_dmemWEN", {31'b0, dmemWEN}, {31'b0, !RST && m_want_data && cu_dWEN});
            check("m_commit", {31'b0, commit}, {31'b0, retire});
            check("m_pc", pc, m_pc);
            check("m_imemaddr", imemaddr, m_pc);
            check("m_pc_plus4", pc_plus4, m_pc + 32'd4);
            check("m_inst", inst, m_inst);
            check("m_halted", {31'b0, halted}, {31'b0, m_stopped});
        end
        if (RST) begin
            m_live = 1'b1;
            m_want_inst = 1'b1; m_decoding = 1'b0; m_want_data = 1'b0; m_stopped = 1'b0;
            m_pc = 32'h0; m_inst = 32'h0;
        end else if (m_live) begin
            if (retire) begin
                m_pc = redirect ? redirect_pc : m_pc + 32'd4;
                m_want_inst = 1'b1; m_decoding = 1'b0; m_want_data = 1'b0;
            end else if (m_want_inst && ihit) begin
                m_inst = iload;
                m_want_inst = 1'b0; m_decoding = 1'b1;
            end else if (m_decoding) begin
                m_decoding = 1'b0;
                if (cu_halt) m_stopped = 1'b1;
                else m_want_data = 1'b1;
            end
        end
    end

    always @(negedge CLK) begin
        if (commit === 1'b1) ncommit++;
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // Fetch one instruction word with a same-cycle hit; returns in EXEC.
    task automatic fetch(input logic [31:0] word, input logic ren, input logic wen, input logic hlt);
        ihit = 1'b1; iload = word;
        cu_dREN = ren; cu_dWEN = wen; cu_halt = hlt;
        cyc();
        ihit = 1'b0; iload = 32'hDEAD_BEEF;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        logic [31:0] frozen;
        int c0;

        // Reset
        RST = 1'b1;
        cyc(); cyc();
        check("rst_imemREN", {31'b0, imemREN}, 32'h0);
        check("rst_pc", pc, 32'h0);
        check("rst_inst", inst, 32'h0);
        check("rst_halted", {31'b0, halted}, 32'h0);
        RST = 1'b0;
        #1;
        check("rst_fetch_req", {31'b0, imemREN}, 32'h1);

        // addi with same-cycle ihit: 2-cycle latency
        fetch(32'h2008_0005, 1'b0, 1'b0, 1'b0);
        check("addi_inst", inst, 32'h2008_0005);
        check("addi_commit", {31'b0, commit}, 32'h1);
        check("addi_exec_noreq", {31'b0, imemREN}, 32'h0);
        cyc();
        check("addi_pc", pc, 32'h4);
        check("addi_refetch", {31'b0, imemREN}, 32'h1);

        // load, dhit delayed by 3 cycles
        fetch(32'h8C22_0000, 1'b1, 1'b0, 1'b0);
        check("lw_exec_dren", {31'b0, dmemREN}, 32'h0);
        cyc();
        for (int k = 0; k < 4; k++) begin
            check("lw_dren", {31'b0, dmemREN}, 32'h1);
            check("lw_noimem", {31'b0, imemREN}, 32'h0);
            if (k == 3) dhit = 1'b1;
            else cyc();
        end
        #1;
        check("lw_commit", {31'b0, commit}, 32'h1);
        cyc();
        dhit = 1'b0;
        check("lw_drop", {31'b0, dmemREN}, 32'h0);
        check("lw_pc", pc, 32'h8);

        // store with redirect at the dhit cycle
        c0 = ncommit;
        fetch(32'hAC22_0000, 1'b0, 1'b1, 1'b0);
        cyc();
        check("sw_dwen", {31'b0, dmemWEN}, 32'h1);
        dhit = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
        cyc();
        dhit = 1'b0; redirect = 1'b0;
        check("sw_drop", {31'b0, dmemWEN}, 32'h0);
        check("sw_pc", pc, 32'h40);
        check("sw_one_commit", ncommit - c0, 32'h1);

        // illegal decode: both read and write, only write is issued
        fetch(32'hAC23_0004, 1'b1, 1'b1, 1'b0);
        cyc();
        check("ill_dwen", {31'b0, dmemWEN}, 32'h1);
        check("ill_dren", {31'b0, dmemREN}, 32'h0);
        dhit = 1'b1;
        cyc();
        dhit = 1'b0; cu_dREN = 1'b0; cu_dWEN = 1'b0;
        check("ill_pc", pc, 32'h44);

        // branch: redirect during FETCH wait is ignored, in EXEC it is taken
        redirect = 1'b1; redirect_pc = 32'h999;
        cyc(); cyc();
        check("br_fetch_ignore", pc, 32'h44);
        fetch(32'h1000_0004, 1'b0, 1'b0, 1'b0);
        redirect_pc = 32'h100;
        cyc();
        redirect = 1'b0;
        check("br_pc", pc, 32'h100);

        // wrap: jump to the top word, then pc + 4 wraps to 0
        fetch(32'h0800_0000, 1'b0, 1'b0, 1'b0);
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        cyc();
        redirect = 1'b0;
        check("wrap_pc", pc, 32'hFFFF_FFFC);
        check("wrap_plus4", pc_plus4, 32'h0);
        fetch(32'h2008_0001, 1'b0, 1'b0, 1'b0);
        cyc();
        check("wrap_seq", pc, 32'h0);
        fetch(32'h2008_0002, 1'b0, 1'b0, 1'b0);
        cyc();
        check("wrap_next", pc, 32'h4);

        // reset in MEM with a simultaneous dhit
        fetch(32'h8C22_0008, 1'b1, 1'b0, 1'b0);
        cyc();
        c0 = ncommit;
        RST = 1'b1; dhit = 1'b1;
        #1;
        check("rstmem_commit", {31'b0, commit}, 32'h0);
        check("rstmem_dren", {31'b0, dmemREN}, 32'h0);
        cyc();
        RST = 1'b0; dhit = 1'b0; cu_dREN = 1'b0;
        check("rstmem_pc", pc, 32'h0);
        check("rstmem_no_commit", ncommit - c0, 32'h0);
        #1;
        check("rstmem_fetch", {31'b0, imemREN}, 32'h1);
        check("rstmem_dren2", {31'b0, dmemREN}, 32'h0);

        // halt: absorbing, pc frozen at the halt instruction
        fetch(32'h2008_0003, 1'b0, 1'b0, 1'b0);
        cyc();
        frozen = pc;
        check("halt_pre_pc", frozen, 32'h4);
        fetch(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
        check("halt_exec_nocommit", {31'b0, commit}, 32'h0);
        cyc();
        check("halt_flag", {31'b0, halted}, 32'h1);
        for (int k = 0; k < 20; k++) begin
            ihit = 1'($urandom_range(0, 1));
            dhit = 1'($urandom_range(0, 1));
            cu_dREN = 1'($urandom_range(0, 1));
            iload = $urandom;
            #1;
            check("halt_reqs", {29'b0, imemREN, dmemREN, dmemWEN}, 32'h0);
            check("halt_pc", pc, frozen);
            cyc();
        end
        check("halt_inst", inst, 32'hFFFF_FFFF);
        check("halt_sticky", {31'b0, halted}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
